// File: rtl/fp_cvt_iter_if.sv
// Request/response bundle between the execute pipeline and the iterative
// int/float converter.
interface fp_cvt_iter_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    modport master (
        output start, op, a,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, op, a,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/fp_cvt_iter.sv
// Iterative signed int <-> IEEE-754 single converter: normalises or aligns the
// mantissa one bit per cycle and packs the result on the exit edge.
module fp_cvt_iter (
    input  logic         clk,
    input  logic         rst_n,
    fp_cvt_iter_if.slave cvt
);
    typedef enum logic [1:0] {IDLE, I2F_NORM, F2I_SHIFT} state_e;

    localparam logic [31:0] MIN_EXACT = 32'hCF00_0000;

    state_e      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic        left_q, left_d;
    logic        triv_q, triv_d;
    logic        tovf_q, tovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;

    logic [7:0]  exp_a;
    assign exp_a = cvt.a[30:23];

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        left_d   = left_q;
        triv_d   = triv_q;
        tovf_d   = tovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (cvt.start) begin
                    busy_d = 1'b1;
                    sign_d = cvt.a[31];
                    cnt_d  = 5'd0;
                    triv_d = 1'b0;
                    tovf_d = 1'b0;
                    left_d = 1'b0;
                    if (!cvt.op) begin
                        mag_d   = cvt.a[31] ? (~cvt.a + 32'd1) : cvt.a;
                        state_d = I2F_NORM;
                    end else begin
                        state_d = F2I_SHIFT;
                        if (exp_a < 8'd127) begin
                            triv_d = 1'b1;
                            mag_d  = 32'd0;
                        end else if (exp_a >= 8'd158) begin
                            // -2^31 is representable exactly; everything else here saturates
                            triv_d = 1'b1;
                            tovf_d = (cvt.a != MIN_EXACT);
                            mag_d  = cvt.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        end else begin
                            mag_d  = {8'd0, 1'b1, cvt.a[22:0]};
                            left_d = (exp_a > 8'd150);
                            cnt_d  = (exp_a > 8'd150) ? 5'(exp_a - 8'd150)
                                                      : 5'(8'd150 - exp_a);
                        end
                    end
                end
            end
            I2F_NORM: begin
                if (mag_q == 32'd0 || mag_q[31]) begin
                    result_d = (mag_q == 32'd0) ? 32'd0
                             : {sign_q, 8'd158 - {3'b000, cnt_q}, mag_q[30:8]};
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            F2I_SHIFT: begin
                if (triv_q || cnt_q == 5'd0) begin
                    // trivial results are already stored with their final sign
                    result_d = (!triv_q && sign_q) ? (~mag_q + 32'd1) : mag_q;
                    ovf_d    = triv_q & tovf_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    mag_d = left_q ? {mag_q[30:0], 1'b0} : {1'b0, mag_q[31:1]};
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        mag_q  <= mag_d;
        cnt_q  <= cnt_d;
        sign_q <= sign_d;
        left_q <= left_d;
        triv_q <= triv_d;
        tovf_q <= tovf_d;
    end

    assign cvt.busy     = busy_q;
    assign cvt.done     = done_q;
    assign cvt.result   = result_q;
    assign cvt.overflow = ovf_q;
endmodule

// File: tb/tb_fp_cvt_iter.sv
// Directed bench for fp_cvt_iter: conversion values, latencies, saturation,
// handshake corner cases and mid-operation reset.
module tb_fp_cvt_iter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;
    logic seen;

    fp_cvt_iter_if cif ();

    fp_cvt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cvt   (cif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        while (cif.done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic o, input logic [31:0] av,
                       input logic [31:0] er, input logic eo, input int el);
        @(negedge clk);
        cif.start = 1'b1;
        cif.op    = o;
        cif.a     = av;
        @(posedge clk);
        #1;
        cif.start = 1'b0;
        lat = 0;
        chk({tag, " busy"}, {31'd0, cif.busy}, 32'd1);
        wait_done();
        chk({tag, " latency"}, lat, el);
        chk({tag, " result"}, cif.result, er);
        chk({tag, " overflow"}, {31'd0, cif.overflow}, {31'd0, eo});
        chk({tag, " busy_at_done"}, {31'd0, cif.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, {31'd0, cif.done}, 32'd0);
        chk({tag, " result_hold"}, cif.result, er);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        lat       = 0;
        seen      = 1'b0;
        rst_n     = 1'b0;
        cif.start = 1'b0;
        cif.op    = 1'b0;
        cif.a     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, cif.busy}, 32'd0);
        chk("rst done", {31'd0, cif.done}, 32'd0);
        chk("rst result", cif.result, 32'd0);
        chk("rst overflow", {31'd0, cif.overflow}, 32'd0);
        rst_n = 1'b1;

        run("i2f_one",    1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 32);
        run("i2f_m5",     1'b0, 32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 30);
        run("i2f_zero",   1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
        run("i2f_min",    1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1);
        run("i2f_max",    1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b0, 2);
        run("f2i_pi",     1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 23);
        run("f2i_m10",    1'b1, 32'hC120_0000, 32'hFFFF_FFF6, 1'b0, 21);
        run("f2i_mhalf",  1'b1, 32'hBF00_0000, 32'h0000_0000, 1'b0, 1);
        run("f2i_sat_p",  1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1);
        run("f2i_ninf",   1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1);
        run("f2i_min",    1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1);
        run("f2i_nan",    1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1);
        run("f2i_e150",   1'b1, 32'h4B00_0000, 32'h0080_0000, 1'b0, 1);
        run("f2i_e157",   1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 8);

        // start pulse while busy must be ignored
        @(negedge clk);
        cif.start = 1'b1;
        cif.op    = 1'b0;
        cif.a     = 32'h0000_0001;
        @(posedge clk);
        #1;
        cif.start = 1'b0;
        lat = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        cif.start = 1'b1;
        cif.op    = 1'b1;
        cif.a     = 32'hC120_0000;
        @(posedge clk);
        #1;
        lat++;
        cif.start = 1'b0;
        wait_done();
        chk("ign latency", lat, 32);
        chk("ign result", cif.result, 32'h3F80_0000);
        chk("ign overflow", {31'd0, cif.overflow}, 32'd0);
        @(posedge clk);
        #1;
        chk("ign no_second_done", {31'd0, cif.done}, 32'd0);
        chk("ign idle", {31'd0, cif.busy}, 32'd0);

        // start in the done cycle is accepted back-to-back
        @(negedge clk);
        cif.start = 1'b1;
        cif.op    = 1'b1;
        cif.a     = 32'h4F00_0000;
        @(posedge clk);
        #1;
        cif.start = 1'b0;
        lat = 0;
        wait_done();
        chk("b2b first result", cif.result, 32'h7FFF_FFFF);
        chk("b2b first ovf", {31'd0, cif.overflow}, 32'd1);
        chk("b2b busy_low", {31'd0, cif.busy}, 32'd0);
        cif.start = 1'b1;
        cif.op    = 1'b0;
        cif.a     = 32'h0000_0002;
        @(posedge clk);
        #1;
        cif.start = 1'b0;
        lat = 0;
        chk("b2b accepted", {31'd0, cif.busy}, 32'd1);
        wait_done();
        chk("b2b second latency", lat, 31);
        chk("b2b second result", cif.result, 32'h4000_0000);
        chk("b2b second ovf", {31'd0, cif.overflow}, 32'd0);
        @(posedge clk);
        #1;

        // reset sampled on E5 of an I2F of 1
        @(negedge clk);
        cif.start = 1'b1;
        cif.op    = 1'b0;
        cif.a     = 32'h0000_0001;
        @(posedge clk);
        #1;
        cif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst busy", {31'd0, cif.busy}, 32'd0);
        chk("mrst done", {31'd0, cif.done}, 32'd0);
        chk("mrst result", cif.result, 32'd0);
        chk("mrst overflow", {31'd0, cif.overflow}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (cif.done === 1'b1 || cif.busy === 1'b1) seen = 1'b1;
        end
        chk("mrst no_done", {31'd0, seen}, 32'd0);
        run("post_rst", 1'b0, 32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
